// File: rtl/edge_pattern_gen.sv
// Programmable square-wave generator with edge strobes and a period counter.
// Drives out high for H cycles and low for L cycles. A finite burst runs P
// periods; P = 0 runs the waveform until stop or reset.
// Optional macro EDGE_PATTERN_GEN_DUTY_CHECK_EN adds the duty_err output. It
// flags a burst whose high and low lengths differ.
module edge_pattern_gen #(
    parameter int CW = 8,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [CW-1:0] high_len,
    input  logic [CW-1:0] low_len,
    input  logic [PW-1:0] periods,
    output logic          out,
    output logic          reclk,
    output logic          feclk,
    output logic          busy,
    output logic          done,
`ifdef EDGE_PATTERN_GEN_DUTY_CHECK_EN
    output logic          duty_err,
`endif
    output logic [PW-1:0] period_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] CONE = CW'(1);
    localparam logic [PW-1:0] PONE = PW'(1);

    state_t        state_q, state_d;
    logic          out_q, out_d;
    logic          reclk_q, reclk_d;
    logic          feclk_q, feclk_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [PW-1:0] period_cnt_q, period_cnt_d;
    logic [CW-1:0] phase_cnt_q, phase_cnt_d;
    logic [CW-1:0] high_q, high_d;
    logic [CW-1:0] low_q, low_d;
    logic [PW-1:0] periods_q, periods_d;
    logic [CW-1:0] highEff;
    logic [CW-1:0] lowEff;
    logic [PW-1:0] periodNext;

    // A zero-length phase is treated as one cycle, so every phase lasts at least one cycle.
    always_comb begin
        highEff    = (high_len == '0) ? CONE : high_len;
        lowEff     = (low_len == '0) ? CONE : low_len;
        periodNext = period_cnt_q + PONE;
    end

    // Next-state and registered-output logic. phase_cnt counts the cycles left
    // in the current phase, minus one.
    always_comb begin
        state_d      = state_q;
        out_d        = out_q;
        reclk_d      = 1'b0;
        feclk_d      = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        period_cnt_d = period_cnt_q;
        phase_cnt_d  = phase_cnt_q;
        high_d       = high_q;
        low_d        = low_q;
        periods_d    = periods_q;
        unique case (state_q)
            IDLE: begin
                out_d  = 1'b0;
                busy_d = 1'b0;
                if (start && !stop) begin
                    high_d       = highEff;
                    low_d        = lowEff;
                    periods_d    = periods;
                    period_cnt_d = '0;
                    phase_cnt_d  = highEff - CONE;
                    state_d      = HIGH;
                    out_d        = 1'b1;
                    reclk_d      = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            HIGH: begin
                if (stop) begin
                    state_d = IDLE;
                    out_d   = 1'b0;
                    busy_d  = 1'b0;
                end else if (phase_cnt_q == '0) begin
                    state_d     = LOW;
                    out_d       = 1'b0;
                    feclk_d     = 1'b1;
                    phase_cnt_d = low_q - CONE;
                end else begin
                    phase_cnt_d = phase_cnt_q - CONE;
                end
            end
            LOW: begin
                if (stop) begin
                    state_d = IDLE;
                    out_d   = 1'b0;
                    busy_d  = 1'b0;
                end else if (phase_cnt_q == '0) begin
                    period_cnt_d = periodNext;
                    if ((periods_q != '0) && (periodNext == periods_q)) begin
                        state_d = DONE;
                        out_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = HIGH;
                        out_d       = 1'b1;
                        reclk_d     = 1'b1;
                        phase_cnt_d = high_q - CONE;
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q - CONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                out_d   = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                out_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            out_q        <= 1'b0;
            reclk_q      <= 1'b0;
            feclk_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            period_cnt_q <= '0;
            phase_cnt_q  <= '0;
            high_q       <= CONE;
            low_q        <= CONE;
            periods_q    <= '0;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            reclk_q      <= reclk_d;
            feclk_q      <= feclk_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            period_cnt_q <= period_cnt_d;
            phase_cnt_q  <= phase_cnt_d;
            high_q       <= high_d;
            low_q        <= low_d;
            periods_q    <= periods_d;
        end
    end

`ifdef EDGE_PATTERN_GEN_DUTY_CHECK_EN
    logic duty_err_q;

    // Capture the duty mismatch flag once per accepted start and hold it for the burst.
    always_ff @(posedge clk) begin
        if (!rst) begin
            duty_err_q <= 1'b0;
        end else if ((state_q == IDLE) && start && !stop) begin
            duty_err_q <= (highEff != lowEff);
        end
    end

    assign duty_err = duty_err_q;
`endif

    assign out        = out_q;
    assign reclk      = reclk_q;
    assign feclk      = feclk_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign period_cnt = period_cnt_q;

endmodule
